tile_guess_checker: RTL
=======================

# tile_guess_checker

Player-side counterpart to the board generator in the memory-matrix game. Captures the generated board pattern at round start, then accepts one tile guess per handshake and scores each as hit, miss or repeat. Tracks found tiles and the miss count, and declares win or lose. Sits between the player input decoder (keys/switches) and the display/score logic.

## Interface
Parameters:
- TILES, default 8: number of tiles; equals the board width.
- IDX_W, default 3: tile-index width; must satisfy 2^IDX_W >= TILES.
- MAX_MISSES, default 3: number of misses that ends the round as lost (1..15).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low.
- board_in  in  TILES  board pattern from the generator; bit i = 1 means tile i is lit.
- load  in  1  one-cycle pulse; captures board_in and starts a new round.
- guess_valid  in  1  guess offered this cycle.
- guess_idx  in  IDX_W  tile index of the offered guess.
- guess_ready  out  1  checker can accept a guess this cycle.
- hit  out  1  one-cycle pulse: the accepted guess found a new lit tile.
- miss  out  1  one-cycle pulse: the accepted guess was an unlit tile or an out-of-range index.
- repeat_guess  out  1  one-cycle pulse: the accepted guess was a lit tile already found.
- found  out  TILES  lit tiles found so far in this round.
- misses  out  4  miss count for this round.
- hits  out  IDX_W+1  number of distinct lit tiles found.
- playing  out  1  state is S_PLAY.
- win  out  1  state is S_WIN.
- lose  out  1  state is S_LOSE.

## Operation
- Registers:
  - board_q[TILES]: board captured by load.
  - found[TILES]
  - misses[4]
  - hits
  - 2-bit state
- States:
  - S_IDLE: after reset; waits for load.
  - S_PLAY: accepting guesses.
  - S_WIN: terminal.
  - S_LOSE: terminal.
- load is honoured in every state:
  - board_q <= board_in; found, misses and hits clear to 0.
  - Next state is S_PLAY. If board_in == 0, next state is S_WIN.
- guess_ready = (state == S_PLAY) && !load. This is combinational from state and load only; it does not depend on guess_valid.
- A guess is accepted when guess_valid && guess_ready. Guesses offered while not ready are ignored; no pulse and no state change.
- Scoring of an accepted guess at index i:
  - i >= TILES: miss.
  - board_q[i] == 0: miss; misses increments. Repeated guesses of the same unlit tile each count as a miss.
  - board_q[i] == 1 and found[i] == 0: hit; found[i] set, hits increments.
  - board_q[i] == 1 and found[i] == 1: repeat_guess; no counters change.
- Transitions out of S_PLAY, on the edge that accepts the guess:
  - If the accepted guess is a hit and (found | onehot(i)) == board_q, go to S_WIN.
  - If the accepted guess is a miss and misses+1 == MAX_MISSES, go to S_LOSE.
  - Otherwise stay in S_PLAY.
- Terminal states hold found, misses and hits until load or reset.
- misses never exceeds MAX_MISSES; no wrap-around.
- reset (reset == 0) has priority over load and over any guess. Reset values:
  - state = S_IDLE
  - board_q, found, misses, hits = 0
  - hit, miss, repeat_guess = 0
  - playing, win, lose = 0
- Reset asserted mid-round discards the round completely.

## Timing
- Guess accepted at rising edge N:
  - found, hits and misses hold the updated values from edge N.
  - The hit, miss or repeat_guess pulse is registered: high for exactly one cycle after edge N, then low.
  - State (and therefore playing/win/lose) updates at edge N.
  - guess_ready drops in the cycle after the winning or losing guess.
- Back-to-back guesses, one per cycle, are supported. Throughput is 1 guess/clk.
- load at edge N: playing = 1 from edge N. guess_ready = 1 in the cycle after load deasserts.
- load and guess_valid in the same cycle: load wins. The guess is not accepted and produces no pulse.
- At most one of hit, miss and repeat_guess is high in any cycle.
- All outputs are registered except guess_ready.

## Test plan
- Win: reset, load with board_in = 8'b1010_0101, then guesses 0, 2, 5, 7 on consecutive cycles.
  - Expect 4 hit pulses, hits = 4, found = 8'hA5, misses = 0.
  - win = 1 after the 4th accept; guess_ready = 0 afterwards.
- Lose: load with board 8'hA5, then guesses 1, 3, 4.
  - Expect miss pulses, misses = 1, 2, 3.
  - lose = 1 after the 3rd accept; a further guess is ignored (no pulse).
- Repeat handling: board 8'hA5, guesses 0, 0, 1, 1.
  - Expect hit, repeat_guess, miss, miss.
  - Final state: hits = 1, misses = 2, still playing.
- Empty board and concurrent load: load with board_in = 0 while guess_valid = 1.
  - Expect win = 1 at the next cycle, no pulses, guess_ready = 0.
- Reload mid-round: load with a new board 8'h0F after 2 hits on 8'hA5.
  - Expect found = 0, hits = 0, misses = 0, playing = 1, board_q = 8'h0F.
- Reset mid-round: hold reset low for 1 cycle during S_PLAY with misses = 2.
  - Expect all outputs 0 and state S_IDLE.
  - Guesses ignored until the next load.

Source files
------------

// File: rtl/tile_guess_checker.sv
// Player-side guess checker for the memory-matrix game: latches the board at
// round start, scores one guess per handshake and tracks win/lose.
module tile_guess_checker #(
  parameter int TILES      = 8,
  parameter int IDX_W      = 3,
  parameter int MAX_MISSES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TILES-1:0] board_in,
  input  logic             load,
  input  logic             guess_valid,
  input  logic [IDX_W-1:0] guess_idx,
  output logic             guess_ready,
  output logic             hit,
  output logic             miss,
  output logic             repeat_guess,
  output logic [TILES-1:0] found,
  output logic [3:0]       misses,
  output logic [IDX_W:0]   hits,
  output logic             playing,
  output logic             win,
  output logic             lose
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_t;

  localparam logic [3:0]       MAX_M   = 4'(MAX_MISSES);
  localparam logic [IDX_W:0]   TILES_W = (IDX_W + 1)'(TILES);
  localparam logic [IDX_W:0]   HIT_ONE = (IDX_W + 1)'(1);
  localparam logic [TILES-1:0] BIT0    = TILES'(1);

  state_t           state_q, state_d;
  logic [TILES-1:0] board_q, board_d;
  logic [TILES-1:0] found_q, found_d;
  logic [3:0]       misses_q, misses_d;
  logic [IDX_W:0]   hits_q, hits_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;
  logic             rep_q, rep_d;

  logic             accept;
  logic             in_range;
  logic             lit;
  logic             already;
  logic [TILES-1:0] onehot;
  logic [TILES-1:0] found_hit;

  // Miss counter saturates at the lose threshold instead of wrapping.
  function automatic logic [3:0] sat_inc_misses(input logic [3:0] cur);
    if (cur >= MAX_M) sat_inc_misses = MAX_M;
    else              sat_inc_misses = cur + 4'd1;
  endfunction

  assign guess_ready = (state_q == S_PLAY) && !load;
  assign accept      = guess_valid && guess_ready;
  assign in_range    = ({1'b0, guess_idx} < TILES_W);
  assign onehot      = in_range ? (BIT0 << guess_idx) : '0;
  assign lit         = |(board_q & onehot);
  assign already     = |(found_q & onehot);
  assign found_hit   = found_q | onehot;

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    found_d  = found_q;
    misses_d = misses_q;
    hits_d   = hits_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    rep_d    = 1'b0;
    if (load) begin
      board_d  = board_in;
      found_d  = '0;
      misses_d = '0;
      hits_d   = '0;
      state_d  = (board_in == '0) ? S_WIN : S_PLAY;
    end else if (accept) begin
      if (!lit) begin
        miss_d   = 1'b1;
        misses_d = sat_inc_misses(misses_q);
        if (sat_inc_misses(misses_q) == MAX_M) state_d = S_LOSE;
      end else if (!already) begin
        hit_d   = 1'b1;
        found_d = found_hit;
        hits_d  = hits_q + HIT_ONE;
        if (found_hit == board_q) state_d = S_WIN;
      end else begin
        rep_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      board_q  <= '0;
      found_q  <= '0;
      misses_q <= '0;
      hits_q   <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      rep_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      found_q  <= found_d;
      misses_q <= misses_d;
      hits_q   <= hits_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      rep_q    <= rep_d;
    end
  end

  assign hit          = hit_q;
  assign miss         = miss_q;
  assign repeat_guess = rep_q;
  assign found        = found_q;
  assign misses       = misses_q;
  assign hits         = hits_q;
  assign playing      = (state_q == S_PLAY);
  assign win          = (state_q == S_WIN);
  assign lose         = (state_q == S_LOSE);

endmodule
